// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit retiring BITS_PER_CYCLE result bits per clock
module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic [3:0]      flags
);
    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0] opr;
    logic [XLEN-1:0] a, b, ma, mb, sres, dsel, res;
    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN:0] t, d;
    logic sgn, spc, dz, ovf, s1, s2, dz_in, ovf_in, accept;
    assign s1 = rs1[XLEN-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
    assign s2 = rs2[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
    assign ma = s1 ? -rs1 : rs1;
    assign mb = s2 ? -rs2 : rs2;
    assign dz_in = op[2] && rs2 == '0;
    assign ovf_in = op[2] && !op[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
    assign sres = dz_in ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign accept = in_valid && in_ready && !flush;
    // Multiply keeps the multiplier in acc low half; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        acc_nx = acc;
        t = '0;
        d = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (opr[2]) begin
                t = acc_nx[2*XLEN-1:XLEN-1];
                acc_nx = acc_nx << 1;
                d = t - {1'b0, b};
                if (!d[XLEN]) begin
                    acc_nx[2*XLEN-1:XLEN] = d[XLEN-1:0];
                    acc_nx[0] = 1'b1;
                end
            end else begin
                t = {1'b0, acc_nx[2*XLEN-1:XLEN]} + (acc_nx[0] ? {1'b0, a} : '0);
                acc_nx = {t, acc_nx[XLEN-1:1]};
            end
        end
    end
    always_comb begin
        state_nx = flush ? IDLE :
                   state == IDLE ? (accept ? ((dz_in || ovf_in) ? FIX : BUSY) : IDLE) :
                   state == BUSY ? (cnt == CW'(ITER - 1) ? FIX : BUSY) :
                   state == FIX  ? DONE :
                   (out_ready ? IDLE : DONE);
    end
    assign prod = sgn ? -acc : acc;
    assign dsel = opr[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    assign res = spc ? acc[XLEN-1:0] :
                 opr[2] ? (sgn ? -dsel : dsel) :
                 opr[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            opr <= '0;
            a <= '0;
            b <= '0;
            acc <= '0;
            sgn <= 1'b0;
            spc <= 1'b0;
            dz <= 1'b0;
            ovf <= 1'b0;
            rd <= '0;
            flags <= '0;
        end else begin
            state <= state_nx;
            cnt <= (state == BUSY && !flush) ? cnt + 1'b1 : '0;
            if (accept) begin
                opr <= op;
                a <= ma;
                b <= mb;
                acc <= {{XLEN{1'b0}}, (dz_in || ovf_in) ? sres : (op[2] ? ma : mb)};
                sgn <= (op[2] && op[1]) ? s1 : s1 ^ s2;
                spc <= dz_in || ovf_in;
                dz <= dz_in;
                ovf <= ovf_in;
            end else if (state == BUSY) begin
                acc <= acc_nx;
            end
            if (state == FIX && !flush) begin
                rd <= res;
                flags <= {1'b0, ovf, dz, res == '0};
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench driving a 1-bit/cycle and a 4-bit/cycle unit against an arithmetic model
module tb_muldiv_iter;
    typedef struct packed {
        logic [31:0] rd;
        logic [3:0]  fl;
        logic [31:0] due;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [1:0] iv = '0, ir, ov, ordy = '0;
    logic [1:0][31:0] rdv;
    logic [1:0][3:0] fl;
    exp_t sb[2][$];
    int cyc = 0, n_pass = 0, n_total = 0, rmode = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]), .op(op),
        .rs1(rs1), .rs2(rs2), .out_valid(ov[0]), .out_ready(ordy[0]), .rd(rdv[0]), .flags(fl[0]));
    muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]), .op(op),
        .rs1(rs1), .rs2(rs2), .out_valid(ov[1]), .out_ready(ordy[1]), .rd(rdv[1]), .flags(fl[1]));
    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction
    // returns {flags, rd} from plain signed/unsigned 64-bit arithmetic
    function automatic logic [35:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] p = '0;
        logic [31:0] r;
        logic dzf = 1'b0, ovf = 1'b0;
        logic big = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sx * sy; r = p[31:0]; end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4: if (y == 0) begin r = '1; dzf = 1'b1; end
                  else if (big) begin r = x; ovf = 1'b1; end
                  else begin p = sx / sy; r = p[31:0]; end
            3'd5: if (y == 0) begin r = '1; dzf = 1'b1; end
                  else begin p = ux / uy; r = p[31:0]; end
            3'd6: if (y == 0) begin r = x; dzf = 1'b1; end
                  else if (big) begin r = '0; ovf = 1'b1; end
                  else begin p = sx % sy; r = p[31:0]; end
            default: if (y == 0) begin r = x; dzf = 1'b1; end
                  else begin p = ux % uy; r = p[31:0]; end
        endcase
        return {1'b0, ovf, dzf, r == 0, r};
    endfunction
    function automatic logic [31:0] rnd_opnd();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction
    // called just after a rising edge; returns just after the accept edge
    task automatic send(input logic [1:0] m, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int w = 0;
        logic [35:0] e;
        while ((ir & m) != m && w < 300) begin
            @(posedge clk); #2;
            w++;
        end
        if ((ir & m) != m) begin
            chk("ready_timeout", 64'(ir & m), 64'(m));
            return;
        end
        op = o; rs1 = x; rs2 = y; iv = m;
        @(posedge clk); #2;
        iv = '0;
        e = ref_model(o, x, y);
        for (int k = 0; k < 2; k++)
            if (m[k]) sb[k].push_back({e[31:0], e[35:32], 32'(cyc + ((e[34] || e[33]) ? 1 : (k == 1 ? 9 : 33)))});
    endtask
    task automatic drain();
        int w = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && w < 1000) begin
            @(posedge clk); #2;
            w++;
        end
        chk("drain", 64'(sb[0].size() + sb[1].size()), 64'(0));
    endtask
    initial forever begin
        @(posedge clk); #3;
        for (int k = 0; k < 2; k++) ordy[k] = rmode == 1 ? 1'b0 : rmode == 2 ? 1'b1 : ($urandom % 4 != 0);
    end
    initial begin
        logic [1:0] pv, pr;
        logic [1:0][31:0] hrd;
        logic [1:0][3:0] hfl;
        exp_t e;
        pv = '0; pr = '0; hrd = '0; hfl = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = '0;
                continue;
            end
            for (int k = 0; k < 2; k++) begin
                if (ov[k] && !pv[k]) begin
                    if (sb[k].size() == 0) chk($sformatf("spurious_valid%0d", k), 64'(ov[k]), 64'(0));
                    else chk($sformatf("latency%0d", k), 64'(cyc), 64'(sb[k][0].due));
                end
                if (ov[k] && pv[k] && !pr[k]) begin
                    chk($sformatf("hold_rd%0d", k), 64'(rdv[k]), 64'(hrd[k]));
                    chk($sformatf("hold_flags%0d", k), 64'(fl[k]), 64'(hfl[k]));
                end
                if (ov[k]) chk($sformatf("in_ready_low%0d", k), 64'(ir[k]), 64'(0));
                if (ov[k] && ordy[k] && sb[k].size() != 0) begin
                    e = sb[k].pop_front();
                    chk($sformatf("rd%0d", k), 64'(rdv[k]), 64'(e.rd));
                    chk($sformatf("flags%0d", k), 64'(fl[k]), 64'(e.fl));
                end
                pv[k] = ov[k]; pr[k] = ordy[k]; hrd[k] = rdv[k]; hfl[k] = fl[k];
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int w;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_in_ready%0d", k), 64'(ir[k]), 64'(1));
            chk($sformatf("rst_out_valid%0d", k), 64'(ov[k]), 64'(0));
            chk($sformatf("rst_rd%0d", k), 64'(rdv[k]), 64'(0));
            chk($sformatf("rst_flags%0d", k), 64'(fl[k]), 64'(0));
        end
        rst_n = 1'b1;
        @(posedge clk); #2;
        send(2'b11, 3'd0, 32'd7, 32'hFFFF_FFFD);
        send(2'b11, 3'd1, 32'h8000_0000, 32'h8000_0000);
        send(2'b11, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(2'b11, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(2'b11, 3'd0, 32'h0001_0000, 32'h0001_0000);
        send(2'b11, 3'd4, 32'hFFFF_FFEC, 32'd3);
        send(2'b11, 3'd6, 32'hFFFF_FFEC, 32'd3);
        send(2'b11, 3'd5, 32'd20, 32'd3);
        send(2'b11, 3'd7, 32'd20, 32'd3);
        send(2'b11, 3'd4, 32'd5, 32'd0);
        send(2'b11, 3'd6, 32'd5, 32'd0);
        send(2'b11, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        send(2'b11, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (150) send(2'b11, 3'($urandom), rnd_opnd(), rnd_opnd());
        drain();
        rmode = 1;
        send(2'b01, 3'd0, 32'($urandom), 32'($urandom));
        w = 0;
        while (!ov[0] && w < 100) begin
            @(posedge clk); #2;
            w++;
        end
        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("bp_out_valid", 64'(ov[0]), 64'(1));
        chk("bp_in_ready", 64'(ir[0]), 64'(0));
        rmode = 2;
        @(posedge clk); #2;
        chk("hs_in_ready", 64'(ir[0]), 64'(1));
        chk("hs_out_valid", 64'(ov[0]), 64'(0));
        send(2'b01, 3'd5, 32'd100, 32'd7);
        drain();
        rmode = 0;
        send(2'b01, 3'd0, 32'($urandom), 32'($urandom));
        repeat (10) begin
            @(posedge clk); #2;
        end
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        chk("flush_in_ready", 64'(ir[0]), 64'(1));
        chk("flush_out_valid", 64'(ov[0]), 64'(0));
        sb[0].delete();
        send(2'b01, 3'd5, 32'd100, 32'd7);
        drain();
        send(2'b01, 3'd0, 32'h1234, 32'h5678);
        repeat (5) begin
            @(posedge clk); #2;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_in_ready%0d", k), 64'(ir[k]), 64'(1));
            chk($sformatf("arst_out_valid%0d", k), 64'(ov[k]), 64'(0));
            chk($sformatf("arst_rd%0d", k), 64'(rdv[k]), 64'(0));
            chk($sformatf("arst_flags%0d", k), 64'(fl[k]), 64'(0));
        end
        sb[0].delete();
        sb[1].delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        send(2'b01, 3'd5, 32'd100, 32'd7);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations. It is the multi-cycle companion to the single-cycle ALU.
- Accepts rs1/rs2/op over a valid/ready handshake and computes BITS_PER_CYCLE result bits per clock.
- Returns rd and a 4-bit flags vector over a second valid/ready handshake.
- Sits beside the ALU in the execute stage; the core stalls while in_ready or out_valid gates progress.

Parameters:
- XLEN, 32, operand and result width; legal values 32 and 64.
- BITS_PER_CYCLE, 1, bits retired per iteration; legal values 1, 2, 4; must divide XLEN.
- Derived: ITER = XLEN/BITS_PER_CYCLE.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of any in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  3  RV funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (dividend / multiplicand).
- rs2  in  XLEN  operand B (divisor / multiplier).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- rd  out  XLEN  result.
- flags  out  4  [0] zero result, [1] divide-by-zero, [2] signed div overflow, [3] reserved (always 0).

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE, out_valid 0, rd 0, flags 0, iteration counter 0, in_ready 1.
- States and transitions:
  - IDLE to BUSY, or IDLE to FIX for the special cases.
  - BUSY to FIX.
  - FIX to DONE.
  - DONE to IDLE.
- in_ready = (state==IDLE). A request is accepted on a rising edge with in_valid && in_ready.
- At accept, the unit latches op and the operand magnitudes.
  - Sign inputs: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed and rs2 unsigned; MULHU/DIVU/REMU treat both as unsigned.
  - Sign registers: the result sign is s1^s2 for product and quotient, and s1 for remainder.
- BUSY runs exactly ITER cycles.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring division with BITS_PER_CYCLE trial subtractions per cycle.
  - The counter increments per cycle; at ITER-1 the state moves to FIX.
- FIX applies two's-complement negation where the sign rule requires it, then selects the output:
  - MUL: low XLEN bits.
  - MULH*: high XLEN bits.
  - DIV*: quotient.
  - REM*: remainder.
  - The selected value and flags are registered, and the state moves to DONE.
- Special cases are detected at accept and go straight to FIX with no BUSY cycles:
  - Divisor 0: DIV/DIVU result all ones, REM/REMU result rs1, flags[1]=1.
  - Signed overflow, DIV/REM with rs1 = most negative and rs2 = all ones: DIV result rs1, REM result 0, flags[2]=1.
- flags[0] = (rd==0), evaluated in FIX for every op.
- Latency, measured from the accept edge E:
  - out_valid rises after edge E+ITER+1 (normal).
  - out_valid rises after edge E+1 (special case).
- DONE:
  - out_valid=1; rd and flags are held stable until out_valid && out_ready.
  - On that handshake edge, go to IDLE and clear out_valid.
  - No new accept occurs in the same cycle (in_ready=0 in DONE).
- flush:
  - Has priority over every transition, including a DONE handshake and an IDLE accept in the same cycle.
  - Next state is IDLE, out_valid 0, counter 0.
  - rd and flags keep their last values but are meaningless.
- Reset mid-operation aborts immediately; no result is produced.
- Unused op bits are impossible (all 8 codes are defined).
- Arithmetic is modulo 2^XLEN; no exceptions are raised.

Test Plan (XLEN=32, BITS_PER_CYCLE=1 unless noted):
1. MUL rs1=7, rs2=0xFFFFFFFD accepted at edge E.
   - rd=0xFFFFFFEB, flags=0.
   - out_valid first high after edge E+33, low before it.
2. MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
   - MUL 0x10000*0x10000 -> 0, flags[0]=1.
3. DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA.
   - REM same operands -> 0xFFFFFFFE.
   - DIVU 20/3 -> 6; REMU 20/3 -> 2.
   - Repeat the DIV case with BITS_PER_CYCLE=4: same result, out_valid after E+9.
4. DIV 5/0 -> 0xFFFFFFFF with flags[1]=1, out_valid after E+1.
   - REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000, flags[2]=1.
   - REM same operands -> 0, flags[0]=1 and flags[2]=1.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles after out_valid: rd, flags and out_valid are stable, in_ready=0.
   - Raise out_ready: the handshake completes and in_ready=1 on the next cycle.
   - A back-to-back request is then accepted correctly.
6. Abort cases:
   - Assert flush at BUSY iteration 10: the unit is in IDLE next cycle, out_valid never rises, and the following DIVU 100/7 returns 14.
   - Repeat with rst_n pulsed low mid-iteration: outputs take reset values asynchronously.
